// File: rtl/rv32m_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32m_pkg                                                  |
// | Brief    : Shared RV32M types, constants and helpers (mul/div units)  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rv32m_pkg;

  localparam int XLEN = 32;

  // Encoding matches funct3[1:0] of DIV/DIVU/REM/REMU.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic is_signed_op(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32m_divider_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : divider_step                                               |
// | Brief    : One combinational restoring shift-subtract division step   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // rem < divisor always holds, so a wrapped (negative) trial sets bit WIDTH.
  assign w_shifted = {rem, quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, divisor};
  assign w_fits    = ~w_trial[WIDTH];

  assign rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/rv32m_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32m_divider                                              |
// | Brief    : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU|
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rv32m_divider
  import rv32m_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int             CW          = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  c_last_step = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  div_op_t          r_op;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;

  div_op_t          w_op_in;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_special;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_fixup;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Special cases are decided straight from the port values on start.
  assign w_op_in    = div_op_t'(op);
  assign w_div_zero = (divisor == '0);
  assign w_overflow = is_signed_op(w_op_in) && (dividend == c_int_min) &&
                      (divisor == c_all_ones);
  assign w_special  = w_div_zero ? (is_rem_op(w_op_in) ? dividend : c_all_ones)
                                 : (is_rem_op(w_op_in) ? '0 : c_int_min);

  assign w_a_neg = is_signed_op(r_op) & r_dividend[WIDTH-1];
  assign w_b_neg = is_signed_op(r_op) & r_divisor[WIDTH-1];
  assign w_a_abs = w_a_neg ? -r_dividend : r_dividend;
  assign w_b_abs = w_b_neg ? -r_divisor  : r_divisor;

  // Sign flags are only ever set for signed ops, so unsigned results pass through.
  assign w_fixup = is_rem_op(r_op) ? (r_r_neg ? -r_rem : r_rem)
                                   : (r_q_neg ? -r_quo : r_quo);

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_divisor),
    .rem_next (w_rem_next),
    .quo_next (w_quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_DIV;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op       <= w_op_in;
            r_dividend <= dividend;
            r_divisor  <= divisor;
            busy       <= 1'b1;
            if (w_div_zero || w_overflow) begin
              result  <= w_special;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_PREP;
            end
          end
        end
        S_PREP: begin
          r_rem     <= '0;
          r_quo     <= w_a_abs;
          r_divisor <= w_b_abs;
          r_q_neg   <= w_a_neg ^ w_b_neg;
          r_r_neg   <= w_a_neg;
          r_cnt     <= '0;
          r_state   <= S_ITER;
        end
        S_ITER: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_step) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          result  <= w_fixup;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32m_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rv32m_divider                                           |
// | Brief    : Scoreboard bench for rv32m_divider with arithmetic model   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_rv32m_divider;

  localparam logic [1:0] c_div  = 2'b00;
  localparam logic [1:0] c_divu = 2'b01;
  localparam logic [1:0] c_rem  = 2'b10;
  localparam logic [1:0] c_remu = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          accept;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= rst;

  rv32m_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void check_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // RISC-V M semantics via plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    longint sa, sb_, ua, ub, q, r;
    bit     sgn;
    sgn = (o == c_div) || (o == c_rem);
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    if (b == 32'h0) begin
      lat = 1;
      q   = 64'hFFFF_FFFF;
      r   = ua;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      q   = 64'h8000_0000;
      r   = 0;
    end else begin
      lat = 35;
      q   = sgn ? sa / sb_ : ua / ub;
      r   = sgn ? sa % sb_ : ua % ub;
    end
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic string op_name(input logic [1:0] o);
    case (o)
      c_div:   return "DIV";
      c_divu:  return "DIVU";
      c_rem:   return "REM";
      default: return "REMU";
    endcase
  endfunction

  function automatic logic [31:0] pick_operand(input int zero_weight);
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < zero_weight) return 32'h0;
    case (sel)
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(1, 20));
      5:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = !busy;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int accept);
    exp_t e;
    e.res    = model(o, a, b, e.lat);
    e.accept = accept;
    e.name   = $sformatf("%s %h/%h", op_name(o), a, b);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_done);
    bit ok;
    wait_idle(ok);
    if (ok) begin
      op       = o;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (expect_done) push_exp(o, a, b, cyc + 1);
      @(posedge clk); #1;
      start    = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
    end
  endtask

  task automatic wait_done_negedge(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = done;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  // Monitor: pops the scoreboard on every done, and checks that result holds in IDLE.
  initial begin
    int          run;
    logic [31:0] held;
    exp_t        e;
    run  = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        held = '0;
        run  = 0;
      end else begin
        if (busy) run++;
        if (done) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done actual=%h required=no_done", result);
          end else begin
            e = sb.pop_front();
            check({e.name, " result"}, result, e.res);
            check_int({e.name, " latency"}, cyc - e.accept + 1, e.lat);
            check_int({e.name, " busy_cycles"}, run, e.lat);
          end
          held = result;
        end else if (!busy) begin
          run = 0;
          check("result_hold", result, held);
        end
      end
    end
  end

  initial begin
    logic [1:0]  d_op [10];
    logic [31:0] d_a  [10];
    logic [31:0] d_b  [10];
    bit          ok;
    int          n;

    d_op = '{c_divu, c_remu, c_div, c_rem, c_div, c_remu, c_divu, c_div, c_rem, c_divu};
    d_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'd0,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    d_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);

    // Abort mid-operation: reset lands on the 10th edge after the accepting edge.
    issue(c_divu, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    issue(c_divu, 32'd9, 32'd3, 1'b1);

    // start held high: second op is accepted the cycle after the first done.
    wait_idle(ok);
    if (ok) begin
      op = c_divu; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      push_exp(c_divu, 32'd1000, 32'd10, cyc + 1);
      wait_done_negedge(ok);
      if (ok) begin
        op = c_rem; dividend = -32'd100; divisor = 32'd7;
        push_exp(c_rem, -32'd100, 32'd7, cyc + 2);
        @(negedge clk);
        wait_done_negedge(ok);
      end
      start = 1'b0;
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand(1);
      rb = pick_operand(2);
      issue(ro, ra, rb, 1'b1);
    end

    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rv32m_divider.md
# rv32m_divider

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse-operation partner of the Wallace-tree multiplier in the execute stage. It accepts one operation per start pulse and iterates one quotient bit per cycle. It signals completion with a one-cycle done pulse and holds the result until the next accepted start. Sign handling and the RISC-V divide-by-zero and overflow rules are resolved inside the block, so the pipeline needs no fixup logic.

## Interface
- width, 32: operand and result width in bits. Must be ≥ 4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only in IDLE; ignored otherwise.
- op  in  2  div_op_t, equal to funct3[1:0]: DIV=00, DIVU=01, REM=10, REMU=11.
- dividend  in  width  rs1. Sampled only on an accepted start.
- divisor  in  width  rs2. Sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  width  quotient or remainder. Held stable from done until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - start=1 captures op and both operands.
  - If divisor==0, or the op is signed with dividend==0x8000_0000 and divisor==0xFFFF_FFFF, go to DONE with the special result.
  - Otherwise go to PREP.
- PREP:
  - For signed ops, take absolute values of both operands.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clear the partial remainder; load the quotient register with |dividend|; clear the counter.
  - Go to ITER.
- ITER, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem − |divisor|, computed width+1 bits wide.
  - If trial is non-negative, rem := trial and quo[0] := 1; else quo[0] := 0.
  - After width steps, go to FIXUP.
- FIXUP:
  - DIV/DIVU: result := quo, negated if q_neg and signed.
  - REM/REMU: result := rem, negated if r_neg and signed.
  - Go to DONE.
- DONE: done=1 for this single cycle, then go to IDLE. start in DONE is ignored.
- Special results (width=32):
  - Divide by zero: quotient = all ones (0xFFFF_FFFF) for both DIV and DIVU; remainder = dividend.
  - Signed overflow: quotient = 0x8000_0000; remainder = 0.
- Unsigned ops ignore the sign bits entirely.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- Normal latency: start sampled at edge T, then PREP at T+1, ITER from T+2 to T+width+1, FIXUP at T+width+2, done at T+width+3. For width=32 that is done 35 cycles after start.
- Special-case latency: done is high in the cycle after start (latency 1).
- busy is high from the first non-IDLE cycle through the DONE cycle. It is never high in IDLE.
- Back-to-back: a start in the cycle after done (IDLE) is accepted. There is no bubble beyond the DONE cycle.
- Reset mid-operation: at the next edge the block returns to IDLE and result=0. The aborted operation produces no done.
- Operand changes while busy have no effect.

## Structure
- rv32m_pkg, shared with the multiplier:
  - div_op_t enum.
  - Constants DIV_BY_ZERO_Q (all ones) and INT_MIN.
  - Helper function abs_val.
- Sub-module divider_step: combinational shift-subtract of one restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and next quo.
  - Instanced once and reused every ITER cycle.
- Top: the FSM, operand/sign registers, the counter (clog2(width)+1 bits), and the fixup mux.

## Test plan
- DIVU 100/7 → done at start+35, result=14. REMU 100/7 → result=2. busy high for exactly 35 cycles.
- DIV 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD (−3). REM of the same operands → 0xFFFF_FFFF (−1). Remainder takes the dividend's sign.
- DIV 5/0 → 0xFFFF_FFFF at start+1. REMU 5/0 → 5. DIVU 0/0 → 0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 at start+1. REM of the same operands → 0. DIVU of the same operands → 0 via the normal 35-cycle path.
- rst asserted at start+10 → IDLE next cycle, result=0, no done. A new start two cycles later (DIVU 9/3) → 3 at its start+35.
- start held high continuously, 2 ops queued on operand changes → each result appears in sequence. starts while busy are ignored; op N+1 is accepted the cycle after op N's done.
